kbest_path_elector: RTL and testbench

- K-best survivor election stage for the 4x4 MIMO tree search. It sits directly downstream of the per-parent 4-child branch sort.
- Takes P parents x 4 children candidate paths with their PEDs. Emits the K_SEL smallest-PED paths, one per cycle, in ascending PED order, over a valid/ready stream.
- These survivors feed the next layer's expansion.

---
 rtl/kbest_path_elector_pkg.sv | 17 +
 rtl/kbest_min_tree.sv | 53 +++++
 rtl/kbest_path_elector.sv | 131 +++++++++++++
 tb/tb_kbest_path_elector.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/kbest_path_elector_pkg.sv
// Shared types for the K-best survivor elector (optional KBEST_PRUNE_EN drops saturated PEDs).
`ifndef ERR_WL
`define ERR_WL 16
`endif

package kbest_path_elector_pkg;
  localparam int unsigned ERR_WL = `ERR_WL;

  typedef enum logic {
    KBE_IDLE  = 1'b0,
    KBE_ELECT = 1'b1
  } kbe_state_t;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/kbest_min_tree.sv
// Binary comparator tree returning the smallest valid PED and its leaf index.
// Used unchanged with or without KBEST_PRUNE_EN.
`ifndef ERR_WL
`define ERR_WL 16
`endif

module kbest_min_tree
  import kbest_path_elector_pkg::*;
#(
  parameter int unsigned W      = 16,
  parameter int unsigned LEAVES = 4,
  localparam int unsigned IW    = idx_w(LEAVES)
) (
  input  logic [LEAVES*W-1:0] ped,
  input  logic [LEAVES-1:0]   valid,
  output logic [W-1:0]        min_ped,
  output logic [IW-1:0]       min_idx,
  output logic                any_valid
);
  localparam int unsigned L2 = 1 << IW;

  // Heap layout: node i has children 2i and 2i+1; leaves sit at L2..2*L2-1.
  // The left child wins ties, which gives lower-index priority.
  always_comb begin : tree
    logic [W-1:0]  n_ped [2*L2];
    logic [IW-1:0] n_idx [2*L2];
    logic          n_val [2*L2];
    for (int unsigned i = 0; i < 2*L2; i++) begin
      n_ped[i] = '0;
      n_idx[i] = '0;
      n_val[i] = 1'b0;
    end
    for (int unsigned i = 0; i < LEAVES; i++) begin
      n_ped[L2+i] = ped[i*W +: W];
      n_idx[L2+i] = IW'(i);
      n_val[L2+i] = valid[i];
    end
    for (int unsigned i = L2 - 1; i > 0; i--) begin
      if (n_val[2*i] && (!n_val[2*i+1] || n_ped[2*i] <= n_ped[2*i+1])) begin
        n_ped[i] = n_ped[2*i];
        n_idx[i] = n_idx[2*i];
        n_val[i] = 1'b1;
      end else begin
        n_ped[i] = n_ped[2*i+1];
        n_idx[i] = n_idx[2*i+1];
        n_val[i] = n_val[2*i+1];
      end
    end
    min_ped   = n_ped[1];
    min_idx   = n_idx[1];
    any_valid = n_val[1];
  end
endmodule

// File: rtl/kbest_path_elector.sv
// K-best survivor election: streams the K_SEL smallest-PED candidate paths in ascending order.
// Optional macro KBEST_PRUNE_EN excludes saturated (all-ones) PEDs and allows early termination.
`ifndef ERR_WL
`define ERR_WL 16
`endif

module kbest_path_elector
  import kbest_path_elector_pkg::*;
#(
  parameter int unsigned N     = 2,
  parameter int unsigned P     = 4,
  parameter int unsigned K_SEL = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [P*4*N*2-1:0]        PATH_in,
  input  logic [P*4*`ERR_WL-1:0]    PED_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N*2-1:0]            PATH_out,
  output logic [`ERR_WL-1:0]        PED_out,
  output logic [idx_w(P)-1:0]       PARENT_out,
  output logic                      done
);
  localparam int unsigned C  = 4*P;
  localparam int unsigned LW = N*2;
  localparam int unsigned PW = idx_w(P);
  localparam int unsigned CW = idx_w(C+1);

  kbe_state_t          state;
  logic [C*LW-1:0]     cand_path;
  logic [C*ERR_WL-1:0] cand_ped;
  logic [C-1:0]        consumed;
  logic [CW-1:0]       cnt;

  logic [P*ERR_WL-1:0] head_ped;
  logic [1:0]          head_child [P];
  logic [P-1:0]        head_any;
  logic [ERR_WL-1:0]   win_ped;
  logic [PW-1:0]       win_parent;
  logic                win_any;
  logic [PW+1:0]       win_idx;
  logic [C-1:0]        win_mask;
  logic                last;

  for (genvar p = 0; p < P; p++) begin : g_par
    kbest_min_tree #(.W(ERR_WL), .LEAVES(4)) u_head (
      .ped      (cand_ped[p*4*ERR_WL +: 4*ERR_WL]),
      .valid    (~consumed[p*4 +: 4]),
      .min_ped  (head_ped[p*ERR_WL +: ERR_WL]),
      .min_idx  (head_child[p]),
      .any_valid(head_any[p])
    );
  end

  kbest_min_tree #(.W(ERR_WL), .LEAVES(P)) u_global (
    .ped      (head_ped),
    .valid    (head_any),
    .min_ped  (win_ped),
    .min_idx  (win_parent),
    .any_valid(win_any)
  );

  // Candidate index is parent*4 + child, which is exactly this concatenation.
  assign win_idx = {win_parent, head_child[win_parent]};

  always_comb begin
    win_mask          = '0;
    win_mask[win_idx] = 1'b1;
  end

`ifdef KBEST_PRUNE_EN
  logic [C-1:0] sat_mask;
  always_comb begin
    sat_mask = '0;
    for (int unsigned c = 0; c < C; c++) sat_mask[c] = &PED_in[c*ERR_WL +: ERR_WL];
  end
  assign last = (cnt == CW'(K_SEL-1)) || ((~consumed & ~win_mask) == '0);
`else
  assign last = (cnt == CW'(K_SEL-1));
`endif

  assign in_ready   = (state == KBE_IDLE);
  assign out_valid  = (state == KBE_ELECT) && win_any;
  assign PATH_out   = out_valid ? cand_path[win_idx*LW +: LW] : '0;
  assign PED_out    = out_valid ? win_ped : '0;
  assign PARENT_out = out_valid ? win_parent : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= KBE_IDLE;
      cand_path <= '0;
      cand_ped  <= '0;
      consumed  <= '0;
      cnt       <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        KBE_IDLE: begin
          if (in_valid) begin
            cand_path <= PATH_in;
            cand_ped  <= PED_in;
            cnt       <= '0;
`ifdef KBEST_PRUNE_EN
            consumed <= sat_mask;
            if (&sat_mask) done  <= 1'b1;
            else           state <= KBE_ELECT;
`else
            consumed <= '0;
            state    <= KBE_ELECT;
`endif
          end
        end
        KBE_ELECT: begin
          if (out_ready) begin
            consumed <= consumed | win_mask;
            cnt      <= cnt + 1'b1;
            if (last) begin
              state <= KBE_IDLE;
              done  <= 1'b1;
            end
          end
        end
        default: state <= KBE_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_kbest_path_elector.sv
// Bench for kbest_path_elector: K_SEL=4 and K_SEL=16 instances; honours KBEST_PRUNE_EN.
`ifndef ERR_WL
`define ERR_WL 16
`endif

module tb_kbest_path_elector;
  localparam int unsigned P  = 4;
  localparam int unsigned C  = 16;
  localparam int unsigned W  = `ERR_WL;
  localparam int unsigned LW = 4;
  localparam int unsigned NT = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic            sel;
  logic            in_valid;
  logic            out_ready;
  logic [C*LW-1:0] path_in;
  logic [C*W-1:0]  ped_in;

  logic a_iv, a_ir, a_ov, a_done, b_iv, b_ir, b_ov, b_done;
  logic [LW-1:0] a_path, b_path;
  logic [W-1:0]  a_ped, b_ped;
  logic [1:0]    a_par, b_par;

  assign a_iv = in_valid & ~sel;
  assign b_iv = in_valid & sel;

  kbest_path_elector #(.N(2), .P(4), .K_SEL(4)) u_dut_k4 (
    .clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_ir), .PATH_in(path_in), .PED_in(ped_in),
    .out_valid(a_ov), .out_ready(out_ready), .PATH_out(a_path), .PED_out(a_ped),
    .PARENT_out(a_par), .done(a_done));

  kbest_path_elector #(.N(2), .P(4), .K_SEL(16)) u_dut_k16 (
    .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_ir), .PATH_in(path_in), .PED_in(ped_in),
    .out_valid(b_ov), .out_ready(out_ready), .PATH_out(b_path), .PED_out(b_ped),
    .PARENT_out(b_par), .done(b_done));

  logic          ov_m, ir_m, done_m;
  logic [LW-1:0] path_m;
  logic [W-1:0]  ped_m;
  logic [1:0]    par_m;
  assign ov_m   = sel ? b_ov   : a_ov;
  assign ir_m   = sel ? b_ir   : a_ir;
  assign done_m = sel ? b_done : a_done;
  assign path_m = sel ? b_path : a_path;
  assign ped_m  = sel ? b_ped  : a_ped;
  assign par_m  = sel ? b_par  : a_par;

  typedef struct packed {
    logic         sel;
    logic [7:0]   stall;
    logic [4:0]   n;
    logic [C*4-1:0] cs;
    logic [C*W-1:0] peds;
  } vec_t;

  vec_t          tbl [NT];
  logic [W-1:0]  cur_ped [C];
  int unsigned   exp_c [C];
  int unsigned   checks = 0;
  int unsigned   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: repeatedly pick the smallest remaining PED, lowest index on ties.
  task automatic model(input int unsigned k, output int unsigned n);
    bit used [C];
    n = 0;
    for (int unsigned c = 0; c < C; c++) used[c] = 1'b0;
`ifdef KBEST_PRUNE_EN
    for (int unsigned c = 0; c < C; c++) if (cur_ped[c] == '1) used[c] = 1'b1;
`endif
    for (int unsigned r = 0; r < k; r++) begin
      int best;
      best = -1;
      for (int c = 0; c < C; c++)
        if (!used[c] && (best < 0 || cur_ped[c] < cur_ped[best])) best = c;
      if (best < 0) break;
      used[best] = 1'b1;
      exp_c[n] = best;
      n++;
    end
  endtask

  task automatic run_set(input string tag, input logic s, input int unsigned stall, input int unsigned n);
    int unsigned waited;
    waited = 0;
    sel = s;
    out_ready = 1'b1;
    for (int unsigned c = 0; c < C; c++) ped_in[c*W +: W] = cur_ped[c];
    while (!ir_m && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk({tag, ".in_ready_idle"}, {31'd0, ir_m}, 32'd1);
    chk({tag, ".out_valid_idle"}, {31'd0, ov_m}, 32'd0);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int unsigned i = 0; i < n; i++) begin
      int unsigned c;
      c = exp_c[i];
      chk($sformatf("%s.out_valid[%0d]", tag, i), {31'd0, ov_m}, 32'd1);
      chk($sformatf("%s.path[%0d]", tag, i), {28'd0, path_m}, c);
      chk($sformatf("%s.ped[%0d]", tag, i), 32'(ped_m), 32'(cur_ped[c]));
      chk($sformatf("%s.parent[%0d]", tag, i), {30'd0, par_m}, c / 4);
      chk($sformatf("%s.busy[%0d]", tag, i), {30'd0, ir_m, done_m}, 32'd0);
      if (i == 0) begin
        for (int unsigned k = 0; k < stall; k++) begin
          out_ready = 1'b0;
          @(negedge clk);
          chk($sformatf("%s.hold_path[%0d]", tag, k), {27'd0, ov_m, path_m}, {27'd1, 1'b1, 4'(c)} & 32'h1f);
          chk($sformatf("%s.hold_ped[%0d]", tag, k), 32'(ped_m), 32'(cur_ped[c]));
        end
      end
      out_ready = 1'b1;
      @(negedge clk);
    end
    chk({tag, ".done"}, {31'd0, done_m}, 32'd1);
    chk({tag, ".end_state"}, {30'd0, ov_m, ir_m}, 32'd1);
    chk({tag, ".end_zero"}, {12'd0, path_m, ped_m}, 32'd0);
    @(negedge clk);
    chk({tag, ".done_pulse"}, {31'd0, done_m}, 32'd0);
  endtask

  initial begin
    int unsigned t1 [C] = '{9, 3, 7, 12, 5, 5, 20, 1, 8, 30, 2, 6, 15, 4, 11, 10};
    int unsigned n;

    for (int unsigned c = 0; c < C; c++) path_in[c*LW +: LW] = LW'(c);
    for (int unsigned t = 0; t < NT; t++) tbl[t] = '0;
    for (int unsigned c = 0; c < C; c++) begin
      tbl[0].peds[c*W +: W] = W'(t1[c]);
      tbl[1].peds[c*W +: W] = W'(7);
      tbl[2].peds[c*W +: W] = W'(t1[c]);
      tbl[3].peds[c*W +: W] = '1;
      tbl[4].peds[c*W +: W] = '1;
    end
    tbl[0].n = 4; tbl[0].cs[15:0] = {4'd13, 4'd1, 4'd10, 4'd7};
    tbl[1].n = 4; tbl[1].cs[15:0] = {4'd3, 4'd2, 4'd1, 4'd0};
    tbl[2].n = 4; tbl[2].cs[15:0] = {4'd13, 4'd1, 4'd10, 4'd7}; tbl[2].stall = 3;
    tbl[3].peds[5*W +: W] = W'(6);
    tbl[3].peds[9*W +: W] = W'(2);
`ifdef KBEST_PRUNE_EN
    tbl[3].n = 2; tbl[3].cs[7:0] = {4'd5, 4'd9};
    tbl[4].n = 0;
`else
    tbl[3].n = 4; tbl[3].cs[15:0] = {4'd1, 4'd0, 4'd5, 4'd9};
    tbl[4].n = 4; tbl[4].cs[15:0] = {4'd3, 4'd2, 4'd1, 4'd0};
`endif

    rst = 1'b1; sel = 1'b0; in_valid = 1'b0; out_ready = 1'b1; ped_in = '0;
    repeat (2) @(negedge clk);
    chk("reset.outputs", {26'd0, a_ov, a_done, b_ov, b_done, 2'd0}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("reset.in_ready", {30'd0, a_ir, b_ir}, 32'd3);
    chk("reset.zero_out", {8'd0, a_ped, a_path, a_par, 2'd0}, 32'd0);

    for (int unsigned t = 0; t < NT; t++) begin
      for (int unsigned c = 0; c < C; c++) cur_ped[c] = tbl[t].peds[c*W +: W];
      for (int unsigned i = 0; i < C; i++) exp_c[i] = 32'(tbl[t].cs[i*4 +: 4]);
      run_set($sformatf("vec%0d", t), tbl[t].sel, tbl[t].stall, tbl[t].n);
    end

    // Reset after the second survivor has been accepted.
    for (int unsigned c = 0; c < C; c++) cur_ped[c] = tbl[0].peds[c*W +: W];
    for (int unsigned c = 0; c < C; c++) ped_in[c*W +: W] = cur_ped[c];
    sel = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid.second", 32'(a_ped), 32'd2);
    @(negedge clk);
    chk("rst_mid.third", 32'(a_ped), 32'd3);
    rst = 1'b1;
    #1;
    chk("rst_mid.ov_drop", {31'd0, a_ov}, 32'd0);
    chk("rst_mid.zero_out", {12'd0, a_path, a_ped}, 32'd0);
    @(negedge clk);
    chk("rst_mid.no_done", {31'd0, a_done}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid.after", {30'd0, a_done, a_ov}, 32'd0);
    chk("rst_mid.in_ready", {31'd0, a_ir}, 32'd1);
    for (int unsigned i = 0; i < C; i++) exp_c[i] = 32'(tbl[0].cs[i*4 +: 4]);
    run_set("rst_reload", 1'b0, 0, 4);

    // Randomized sets against the reference model on both instances.
    for (int unsigned r = 0; r < 16; r++) begin
      logic s;
      s = r[0];
      for (int unsigned c = 0; c < C; c++) begin
        if ($urandom_range(0, 7) == 0) cur_ped[c] = '1;
        else if (r < 8)                cur_ped[c] = W'($urandom_range(0, 15));
        else                           cur_ped[c] = W'($urandom_range(0, (1 << W) - 2));
      end
      model(s ? 16 : 4, n);
      run_set($sformatf("rand%0d", r), s, $urandom_range(0, 2), n);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
